// File: rtl/phy_rx_pkg.sv
// Shared phy_rx definitions: symbol constants and the receive deserializer state type.
// Symbol values are common with phy_tx so both ends agree on the idle/alignment pattern.
package phy_rx_pkg;

    localparam int unsigned SYM_WIDTH          = 8;
    localparam logic [7:0]  COMMA_SYM          = 8'hBC;
    localparam int unsigned LOCK_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx_comma_detect.sv
// Bit-serial shift register with a sliding-window COMMA compare.
// word always holds the newest WIDTH bits, including the bit currently on serial_in.
module comma_detect
    import phy_rx_pkg::*;
#(
    parameter int unsigned      WIDTH = SYM_WIDTH,
    parameter logic [WIDTH-1:0] COMMA = COMMA_SYM
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word,
    output logic             is_comma
);

    // Only WIDTH-1 history bits are stored; the oldest bit would be shifted out unused.
    logic [WIDTH-2:0] sr;

    assign word     = {sr, serial_in};
    assign is_comma = (word == COMMA);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= word[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Per-lane receive deserializer: aligns on COMMA, locks after LOCK_COUNT aligned COMMAs,
// then presents each non-COMMA symbol on data_out with valid_out for one symbol period.
module serial_paralelo_rx
    import phy_rx_pkg::*;
#(
    parameter int unsigned      WIDTH      = SYM_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_SYM,
    parameter int unsigned      LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_VAL = CW'(LOCK_COUNT);

    rx_state_e        state;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    bc_cnt;
    logic [WIDTH-1:0] word;
    logic             is_comma;

    logic [BW-1:0]    bit_cnt_next;
    logic [CW-1:0]    bc_cnt_inc;
    logic             symbol_end;

    comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .serial_in (serial_in),
        .word      (word),
        .is_comma  (is_comma)
    );

    // bc_cnt saturates at LOCK_COUNT so it can never wrap back below the lock threshold.
    always_comb begin
        symbol_end   = (bit_cnt == LAST_BIT);
        bit_cnt_next = symbol_end ? '0 : bit_cnt + 1'b1;
        bc_cnt_inc   = (bc_cnt == LOCK_VAL) ? bc_cnt : bc_cnt + 1'b1;
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state       <= SEARCH;
            bit_cnt     <= '0;
            bc_cnt      <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt <= '0;
                        bc_cnt  <= CW'(1);
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt_next;
                    if (symbol_end) begin
                        if (is_comma) begin
                            bc_cnt <= bc_cnt_inc;
                            if (bc_cnt_inc == LOCK_VAL) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= bit_cnt_next;
                    if (symbol_end) begin
                        byte_strobe <= 1'b1;
                        if (is_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= word;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: directed scenarios plus randomized traffic
// compared against a bit-position reference model of the alignment and lock rules.
module tb_serial_paralelo_rx;

    logic       clk_8f    = 1'b0;
    logic       reset     = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: alignment is an anchor bit index; symbol checks fall every 8 bits after it.
    logic   hist[$];
    bit     m_aligned, m_locked, m_valid, m_strobe;
    int     m_anchor, m_cnt, m_n;
    logic [7:0] m_data;

    serial_paralelo_rx #(
        .WIDTH      (8),
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic drive_bit(input logic b, input logic r);
        logic [7:0] w;
        serial_in = b;
        reset     = r;
        @(posedge clk_8f);
        #1;
        if (r) begin
            hist.delete();
            m_aligned = 0; m_locked = 0; m_valid = 0; m_strobe = 0;
            m_anchor  = 0; m_cnt    = 0; m_n     = 0; m_data   = 8'h00;
        end else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            w = 8'h00;
            for (int i = 0; i < 8; i++) begin
                int idx;
                idx = int'(hist.size()) - 8 + i;
                w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
            end
            m_strobe = 0;
            if (!m_aligned) begin
                if (w == 8'hBC) begin
                    m_aligned = 1; m_anchor = m_n; m_cnt = 1;
                end
            end else if ((m_n - m_anchor) % 8 == 0) begin
                if (!m_locked) begin
                    if (w == 8'hBC) begin
                        m_cnt++;
                        if (m_cnt == 4) m_locked = 1;
                    end else begin
                        m_aligned = 0; m_cnt = 0;
                    end
                end else begin
                    m_strobe = 1;
                    if (w == 8'hBC) m_valid = 0;
                    else begin m_data = w; m_valid = 1; end
                end
            end
            m_n++;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_bit(v[i], 1'b0);
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            drive_bit(1'($urandom_range(0, 1)), 1'b1);
            vectors++;
            if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got data=%h v=%b s=%b a=%b, want all 0",
                         c, data_out, valid_out, byte_strobe, active);
            end
        end
        for (int c = 0; c < 10; c++) begin
            drive_bit(1'b0, 1'b0);
            vectors++;
            if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got data=%h v=%b s=%b a=%b, want all 0",
                         c, data_out, valid_out, byte_strobe, active);
            end
        end
    endtask

    task automatic test_lock;
        logic [7:0] bc;
        bc = 8'hBC;
        drive_bit(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive_bit(bc[7 - (i % 8)], 1'b0);
            vectors++;
            if (active !== (i == 31) || valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL lock bit %0d: got active=%b valid=%b, want active=%b valid=0",
                         i, active, valid_out, (i == 31));
            end
        end
    endtask

    task automatic test_data;
        logic [7:0] bytes [5] = '{8'hBC, 8'hFF, 8'hEE, 8'hBC, 8'hDD};
        logic [7:0] exp_d [5] = '{8'h00, 8'hFF, 8'hEE, 8'hEE, 8'hDD};
        logic       exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] pd;
        logic       pv;
        int         strobes;
        strobes = 0;
        for (int k = 0; k < 5; k++) begin
            pd = (k == 0) ? 8'h00 : exp_d[k-1];
            pv = (k == 0) ? 1'b0  : exp_v[k-1];
            for (int j = 0; j < 8; j++) begin
                drive_bit(bytes[k][7 - j], 1'b0);
                if (byte_strobe === 1'b1) strobes++;
                vectors++;
                if (j == 7) begin
                    if (data_out !== exp_d[k] || valid_out !== exp_v[k] || byte_strobe !== 1'b1) begin
                        miscompares++;
                        $display("FAIL data byte %0d end: got data=%h v=%b s=%b, want data=%h v=%b s=1",
                                 k, data_out, valid_out, byte_strobe, exp_d[k], exp_v[k]);
                    end
                end else if (data_out !== pd || valid_out !== pv || byte_strobe !== 1'b0) begin
                    miscompares++;
                    $display("FAIL data byte %0d hold bit %0d: got data=%h v=%b s=%b, want data=%h v=%b s=0",
                             k, j, data_out, valid_out, byte_strobe, pd, pv);
                end
            end
        end
        vectors++;
        if (strobes != 5) begin
            miscompares++;
            $display("FAIL data strobe_count: got %0d, want 5", strobes);
        end
    endtask

    task automatic test_broken_align;
        drive_bit(1'b0, 1'b1);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h32);
        vectors++;
        if (active !== 1'b0) begin
            miscompares++;
            $display("FAIL broken_align after_32: got active=%b, want 0", active);
        end
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        vectors++;
        if (active !== 1'b0) begin
            miscompares++;
            $display("FAIL broken_align three_bc: got active=%b, want 0", active);
        end
        send_byte(8'hBC);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL broken_align relock: got active=%b, want 1", active);
        end
    endtask

    task automatic test_midrun_reset;
        logic [7:0] aa;
        aa = 8'hAA;
        drive_bit(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun locked: got active=%b, want 1", active);
        end
        for (int j = 0; j < 3; j++) drive_bit(aa[7 - j], 1'b0);
        drive_bit(aa[4], 1'b1);
        vectors++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
            miscompares++;
            $display("FAIL midrun reset_edge: got data=%h v=%b s=%b a=%b, want all 0",
                     data_out, valid_out, byte_strobe, active);
        end
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        vectors++;
        if (active !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun three_bc: got active=%b, want 0", active);
        end
        send_byte(8'hBC);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun relock: got active=%b, want 1", active);
        end
    endtask

    task automatic test_false_match;
        drive_bit(1'b0, 1'b1);
        send_byte(8'h0B);
        send_byte(8'hC5);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        vectors++;
        if (active !== 1'b0) begin
            miscompares++;
            $display("FAIL false_match early_lock: got active=%b, want 0", active);
        end
        send_byte(8'hBC);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL false_match real_lock: got active=%b, want 1", active);
        end
    endtask

    task automatic test_random;
        logic [7:0] v;
        drive_bit(1'b0, 1'b1);
        for (int r = 0; r < 24; r++) begin
            int nb;
            logic [7:0] syms[$];
            syms.delete();
            nb = $urandom_range(0, 11);
            for (int k = 0; k < $urandom_range(4, 6); k++) syms.push_back(8'hBC);
            for (int k = 0; k < $urandom_range(1, 6); k++) begin
                v = 8'($urandom_range(0, 255));
                if (v == 8'hBC || $urandom_range(0, 5) == 0) v = (v == 8'hBC) ? 8'h3C : 8'hBC;
                syms.push_back(v);
            end
            for (int i = 0; i < nb + syms.size() * 8; i++) begin
                logic b, rs;
                if (i < nb) b = 1'($urandom_range(0, 1));
                else        b = syms[(i - nb) / 8][7 - ((i - nb) % 8)];
                rs = (r % 7 == 6) && (i == nb + 13);
                drive_bit(b, rs);
                vectors++;
                if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_locked}) begin
                    miscompares++;
                    $display("FAIL random r%0d i%0d: got data=%h v=%b s=%b a=%b, want data=%h v=%b s=%b a=%b",
                             r, i, data_out, valid_out, byte_strobe, active,
                             m_data, m_valid, m_strobe, m_locked);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_lock();
        test_data();
        test_broken_align();
        test_midrun_reset();
        test_false_match();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
